bit_plane_seq: RTL and testbench

Sequencer that drives the 3-bit plane select of the 8:1 bit-plane multiplexer feeding the 1152-bit register array datapath. On a START pulse it steps the select through 1–8 bit planes, LSB- or MSB-first, for a programmable number of passes, under a VALID/READY handshake with the downstream shift-accumulate stage. It also emits first/last/sign markers so the accumulator can clear, shift, and negate the two's-complement MSB plane.

---
 rtl/bit_plane_seq.sv | 121 ++++++++++++
 tb/tb_bit_plane_seq.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/bit_plane_seq.sv
// Bit-plane select sequencer: steps the 8:1 plane mux through 1..8 planes per pass
// for a programmable number of passes, with first/last/sign markers for the accumulator.
module bit_plane_seq #(
  parameter bit MSB_FIRST = 1'b0,
  parameter int LW        = 8
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          START,
  input  logic          ABORT,
  input  logic [2:0]    BIT_NUM,
  input  logic [LW-1:0] LOOP_NUM,
  input  logic          SIGNED_EN,
  input  logic          BIT_READY,
  output logic [2:0]    CTRL_MUX_8_1,
  output logic          BIT_VALID,
  output logic          BIT_FIRST,
  output logic          BIT_LAST,
  output logic          SIGN_BIT,
  output logic          LOOP_LAST,
  output logic          BUSY,
  output logic          DONE
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t        r_state;
  logic [2:0]    r_bit_cnt;
  logic [LW-1:0] r_loop_cnt;
  logic [2:0]    r_bit_max;
  logic [LW-1:0] r_loop_max;
  logic          r_signed;

  state_t        w_state_nxt;
  logic [2:0]    w_bit_nxt;
  logic [LW-1:0] w_loop_nxt;
  logic          w_latch;
  logic          w_run;
  logic          w_accept;
  logic          w_bit_end;
  logic          w_loop_end;
  logic [2:0]    w_plane;

  assign w_run      = (r_state == S_RUN);
  assign w_accept   = w_run & BIT_READY;
  assign w_bit_end  = (r_bit_cnt == r_bit_max);
  assign w_loop_end = (r_loop_cnt == r_loop_max);

  always_comb begin
    w_state_nxt = r_state;
    w_bit_nxt   = r_bit_cnt;
    w_loop_nxt  = r_loop_cnt;
    w_latch     = 1'b0;
    if (ABORT) begin
      w_state_nxt = S_IDLE;
      w_bit_nxt   = '0;
      w_loop_nxt  = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (START) begin
            w_state_nxt = S_RUN;
            w_bit_nxt   = '0;
            w_loop_nxt  = '0;
            w_latch     = 1'b1;
          end
        end
        S_RUN: begin
          if (w_accept) begin
            if (!w_bit_end) begin
              w_bit_nxt = r_bit_cnt + 3'd1;
            end else if (!w_loop_end) begin
              w_bit_nxt  = '0;
              w_loop_nxt = r_loop_cnt + LW'(1);
            end else begin
              // Counters cleared on the way out so FIN/IDLE decode to zero
              w_state_nxt = S_FIN;
              w_bit_nxt   = '0;
              w_loop_nxt  = '0;
            end
          end
        end
        S_FIN:   w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= S_IDLE;
      r_bit_cnt  <= '0;
      r_loop_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_loop_cnt <= w_loop_nxt;
    end
  end

  // Run configuration is only observed while in RUN, so it needs no reset
  always_ff @(posedge CLK) begin
    if (w_latch) begin
      r_bit_max  <= BIT_NUM;
      r_loop_max <= LOOP_NUM;
      r_signed   <= SIGNED_EN;
    end
  end

  assign w_plane = MSB_FIRST ? (r_bit_max - r_bit_cnt) : r_bit_cnt;

  assign CTRL_MUX_8_1 = w_run ? w_plane : 3'd0;
  assign BIT_VALID    = w_run;
  assign BIT_FIRST    = w_run & (r_bit_cnt == 3'd0);
  assign BIT_LAST     = w_run & w_bit_end;
  assign LOOP_LAST    = w_run & w_loop_end;
  assign SIGN_BIT     = w_run & r_signed & (w_plane == r_bit_max);
  assign BUSY         = (r_state != S_IDLE);
  assign DONE         = (r_state == S_FIN);

endmodule

// File: tb/tb_bit_plane_seq.sv
// Directed bench for bit_plane_seq: one LSB-first and one MSB-first instance share stimulus.
module tb_bit_plane_seq;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       START, ABORT, SIGNED_EN, BIT_READY;
  logic [2:0] BIT_NUM;
  logic [7:0] LOOP_NUM;

  logic [2:0] mux_l, mux_m;
  logic vld_l, first_l, last_l, sign_l, llast_l, busy_l, done_l;
  logic vld_m, first_m, last_m, sign_m, llast_m, busy_m, done_m;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  bit_plane_seq #(.MSB_FIRST(1'b0), .LW(8)) u_lsb (
    .CLK(CLK), .RST_N(RST_N), .START(START), .ABORT(ABORT),
    .BIT_NUM(BIT_NUM), .LOOP_NUM(LOOP_NUM), .SIGNED_EN(SIGNED_EN), .BIT_READY(BIT_READY),
    .CTRL_MUX_8_1(mux_l), .BIT_VALID(vld_l), .BIT_FIRST(first_l), .BIT_LAST(last_l),
    .SIGN_BIT(sign_l), .LOOP_LAST(llast_l), .BUSY(busy_l), .DONE(done_l)
  );

  bit_plane_seq #(.MSB_FIRST(1'b1), .LW(8)) u_msb (
    .CLK(CLK), .RST_N(RST_N), .START(START), .ABORT(ABORT),
    .BIT_NUM(BIT_NUM), .LOOP_NUM(LOOP_NUM), .SIGNED_EN(SIGNED_EN), .BIT_READY(BIT_READY),
    .CTRL_MUX_8_1(mux_m), .BIT_VALID(vld_m), .BIT_FIRST(first_m), .BIT_LAST(last_m),
    .SIGN_BIT(sign_m), .LOOP_LAST(llast_m), .BUSY(busy_m), .DONE(done_m)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Both instances see identical control timing; only plane order and sign position differ
  task automatic chk_out(input string tag, input logic vld, input logic [31:0] pl,
                         input logic [31:0] pm, input logic first, input logic last,
                         input logic sl, input logic sm, input logic llast,
                         input logic busy, input logic done);
    chk({tag, ".mux_l"}, mux_l, pl);
    chk({tag, ".mux_m"}, mux_m, pm);
    chk({tag, ".valid"}, vld_l, vld);
    chk({tag, ".valid_m"}, vld_m, vld);
    chk({tag, ".first"}, first_l, first);
    chk({tag, ".last"}, last_l, last);
    chk({tag, ".sign_l"}, sign_l, sl);
    chk({tag, ".sign_m"}, sign_m, sm);
    chk({tag, ".loop_last"}, llast_l, llast);
    chk({tag, ".busy"}, busy_l, busy);
    chk({tag, ".done"}, done_l, done);
    chk({tag, ".done_m"}, done_m, done);
  endtask

  task automatic chk_idle(input string tag);
    chk_out(tag, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Unstalled run started at the current negedge; ends on the first IDLE cycle.
  // poke: beat index during which START is pulsed again (must be ignored), -1 for none.
  task automatic run_seq(input string tag, input int bnum, input int lnum,
                         input logic sg, input int poke);
    int k;
    BIT_NUM   = bnum[2:0];
    LOOP_NUM  = lnum[7:0];
    SIGNED_EN = sg;
    BIT_READY = 1'b1;
    START     = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    k = 0;
    for (int l = 0; l <= lnum; l++) begin
      for (int b = 0; b <= bnum; b++) begin
        chk_out($sformatf("%s.p%0d.b%0d", tag, l, b), 1'b1, b, bnum - b,
                b == 0, b == bnum, sg && (b == bnum), sg && (b == 0),
                l == lnum, 1'b1, 1'b0);
        START = (k == poke);
        k++;
        @(negedge CLK);
      end
    end
    START = 1'b0;
    chk_out({tag, ".fin"}, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge CLK);
    chk_idle({tag, ".idle"});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int cyc;
    RST_N = 1'b0; START = 1'b0; ABORT = 1'b0; SIGNED_EN = 1'b0;
    BIT_READY = 1'b0; BIT_NUM = 3'd0; LOOP_NUM = 8'd0;
    repeat (2) @(negedge CLK);
    chk_idle("rst");
    RST_N = 1'b1;
    @(negedge CLK);
    chk_idle("post_rst");

    // 8 planes, one pass; second run starts in the cycle after DONE
    run_seq("p8", 7, 0, 1'b0, -1);
    run_seq("b2b", 3, 1, 1'b1, -1);
    // single plane, three passes, START re-pulsed mid-run
    run_seq("one", 0, 2, 1'b1, 1);
    @(negedge CLK);
    chk_idle("no_restart");

    // READY pattern 1,0,0,1,0,0,... : accepts on cycles 0,3,6,9,12,15
    BIT_NUM = 3'd5; LOOP_NUM = 8'd0; SIGNED_EN = 1'b0; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    idx = 0;
    cyc = 0;
    while (idx < 6 && cyc < 100) begin
      chk_out($sformatf("stall.c%0d", cyc), 1'b1, idx, 5 - idx, idx == 0, idx == 5,
              1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      BIT_READY = (cyc % 3 == 0);
      if (BIT_READY) idx++;
      cyc++;
      @(negedge CLK);
    end
    BIT_READY = 1'b1;
    chk("stall.beats", idx, 6);
    chk("stall.cycles", cyc, 16);
    chk_out("stall.fin", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge CLK);
    chk_idle("stall.idle");

    // ABORT and START together in IDLE
    ABORT = 1'b1; START = 1'b1;
    @(negedge CLK);
    ABORT = 1'b0; START = 1'b0;
    chk_idle("abort_start");

    // ABORT on the third beat of an 8-plane run
    BIT_NUM = 3'd7; LOOP_NUM = 8'd0; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_out($sformatf("abort.b%0d", i), 1'b1, i, 7 - i, i == 0, 1'b0,
              1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      if (i == 2) ABORT = 1'b1;
      @(negedge CLK);
    end
    ABORT = 1'b0;
    chk_idle("abort.idle");
    @(negedge CLK);
    chk_idle("abort.nodone");

    // asynchronous reset mid-run
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    chk_out("rst_run.b0", 1'b1, 0, 7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge CLK);
    chk_out("rst_run.b1", 1'b1, 1, 6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    RST_N = 1'b0;
    #1;
    chk_idle("rst_async");
    @(negedge CLK);
    chk_idle("rst_hold");
    RST_N = 1'b1;
    @(negedge CLK);
    chk_idle("rst_nodone");
    run_seq("after_rst", 7, 0, 1'b0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
